bp_cache_assoc: RTL and testbench

Parametrised N-way set-associative successor to the direct-mapped branch-predictor cache. It provides two combinational read ports (fetch-side lookup) and one synchronous write port (resolve-side update) over a tag/valid/data store. Replacement is round-robin per set, with invalid ways filled first. It sits between the fetch stage's branch predictor and the execute-stage branch resolution update path.

---
 rtl/bp_cache_assoc.sv | 162 ++++++++++++++++
 tb/tb_bp_cache_assoc.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bp_cache_assoc.sv
// bp_cache_assoc
//   N-way set-associative branch-predictor cache. Two combinational lookup
//   ports serve fetch, and one synchronous update port serves resolve.
//   Each entry holds a valid bit, a tag and a payload.
//   Replacement works per set: an invalid way is filled first. When the
//   set is full, the victim is chosen round-robin.
//
//   Optional feature macro: BP_CACHE_BYPASS_EN
//     defined   : a write forwards to any read port whose address equals wa
//                 in the same cycle
//     undefined : read ports see committed state only
//
// Ports
//   clk            clock, all state updates on the rising edge
//   reset          synchronous, active-high; clears valid bits and victim
//                  pointers, and drops any write in the same cycle
//   ra0/ra1        lookup addresses (word address)
//   dout0/dout1    payload of the matching way, 0 on miss
//   hit0/hit1      lookup hit
//   wa, din, we    update address, payload and enable
//   evict          the current write replaces a valid entry with a different tag
module bp_cache_assoc #(
  parameter int AWIDTH = 30,
  parameter int DWIDTH = 2,
  parameter int LINES  = 128,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] ra0,
  output logic [DWIDTH-1:0] dout0,
  output logic              hit0,
  input  logic [AWIDTH-1:0] ra1,
  output logic [DWIDTH-1:0] dout1,
  output logic              hit1,
  input  logic [AWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] din,
  input  logic              we,
  output logic              evict
);

  localparam int SETS  = LINES / WAYS;
  localparam int IBITS = $clog2(SETS);
  localparam int TBITS = AWIDTH - IBITS;
  // Index and pointer widths are kept at least 1 bit wide. With a single
  // set the index is tied to 0. With a single way the pointer stays 0.
  localparam int IW    = (IBITS > 0) ? IBITS : 1;
  localparam int PW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [TBITS-1:0]  tag_q   [SETS][WAYS];
  logic [DWIDTH-1:0] data_q  [SETS][WAYS];
  logic [PW-1:0]     ptr_q   [SETS];

  logic [IW-1:0]     idx0, idx1, widx;
  logic [TBITS-1:0]  tag0, tag1, wtag;

  generate
    if (IBITS > 0) begin : g_idx
      assign idx0 = ra0[IBITS-1:0];
      assign idx1 = ra1[IBITS-1:0];
      assign widx = wa[IBITS-1:0];
    end else begin : g_noidx
      assign idx0 = '0;
      assign idx1 = '0;
      assign widx = '0;
    end
  endgenerate

  assign tag0 = ra0[AWIDTH-1:IBITS];
  assign tag1 = ra1[AWIDTH-1:IBITS];
  assign wtag = wa[AWIDTH-1:IBITS];

  // Lookup ports. The write policy keeps at most one matching way per set,
  // so a plain scan is equivalent to an OR-mux.
  logic              hit0_raw, hit1_raw;
  logic [DWIDTH-1:0] dout0_raw, dout1_raw;

  always_comb begin
    hit0_raw  = 1'b0;
    dout0_raw = '0;
    hit1_raw  = 1'b0;
    dout1_raw = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx0][w] && (tag_q[idx0][w] == tag0)) begin
        hit0_raw  = 1'b1;
        dout0_raw = data_q[idx0][w];
      end
      if (valid_q[idx1][w] && (tag_q[idx1][w] == tag1)) begin
        hit1_raw  = 1'b1;
        dout1_raw = data_q[idx1][w];
      end
    end
  end

  // Update-side way selection. A tag hit has priority. Otherwise the
  // lowest-index invalid way is used. Otherwise the victim pointer is used.
  logic          w_hit, w_inv, wr_en, repl;
  logic [PW-1:0] w_hit_way, w_inv_way, way_sel, ptr_next;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_inv     = 1'b0;
    w_inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[widx][w] && (tag_q[widx][w] == wtag)) begin
        w_hit     = 1'b1;
        w_hit_way = PW'(w);
      end
      if (!valid_q[widx][w] && !w_inv) begin
        w_inv     = 1'b1;
        w_inv_way = PW'(w);
      end
    end
  end

  assign wr_en   = we && !reset;
  assign repl    = !w_hit && !w_inv;
  assign way_sel = w_hit ? w_hit_way : (w_inv ? w_inv_way : ptr_q[widx]);
  // With a power-of-two way count, natural wrap of the pointer gives mod WAYS.
  assign ptr_next = (WAYS > 1) ? (ptr_q[widx] + 1'b1) : '0;
  assign evict   = wr_en && repl;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else if (we) begin
      valid_q[widx][way_sel] <= 1'b1;
      if (repl) begin
        ptr_q[widx] <= ptr_next;
      end
    end
  end

  // Tag and payload arrays are left uncleared by reset. Entries are
  // qualified by their valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[widx][way_sel]  <= wtag;
      data_q[widx][way_sel] <= din;
    end
  end

  logic byp0, byp1;
`ifdef BP_CACHE_BYPASS_EN
  assign byp0 = we && (ra0 == wa);
  assign byp1 = we && (ra1 == wa);
`else
  assign byp0 = 1'b0;
  assign byp1 = 1'b0;
`endif

  assign hit0  = !reset && (byp0 || hit0_raw);
  assign hit1  = !reset && (byp1 || hit1_raw);
  assign dout0 = reset ? '0 : (byp0 ? din : dout0_raw);
  assign dout1 = reset ? '0 : (byp1 ? din : dout1_raw);

endmodule

// File: tb/tb_bp_cache_assoc.sv
// Directed scoreboard bench for bp_cache_assoc with default parameters:
// 64 sets, 2 ways, index = addr[5:0].
// The stimulus queues the expected outputs for each cycle it drives. The
// monitor pops and compares them on the falling edge of that cycle.
module tb_bp_cache_assoc;

  logic        clk;
  logic        reset;
  logic [29:0] ra0, ra1, wa;
  logic [1:0]  dout0, dout1, din;
  logic        hit0, hit1, we, evict;

  bp_cache_assoc #(.AWIDTH(30), .DWIDTH(2), .LINES(128), .WAYS(2)) dut (
    .clk(clk), .reset(reset),
    .ra0(ra0), .dout0(dout0), .hit0(hit0),
    .ra1(ra1), .dout1(dout1), .hit1(hit1),
    .wa(wa), .din(din), .we(we), .evict(evict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All of A..F map to index 0x3F and carry distinct tags. X uses index 0x2A.
  localparam logic [29:0] A = 30'h1555557F;
  localparam logic [29:0] B = 30'h0000007F;
  localparam logic [29:0] C = 30'h0000013F;
  localparam logic [29:0] D = 30'h000001BF;
  localparam logic [29:0] E = 30'h000000BF;
  localparam logic [29:0] F = 30'h0000023F;
  localparam logic [29:0] X = 30'h2AAAAAAA;
  localparam logic [29:0] Z = 30'h00000000;

  typedef struct {
    int          cyc;
    string       nm;
    logic        h0;
    logic [1:0]  d0;
    logic        h1;
    logic [1:0]  d1;
    logic        ev;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string fld, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h (t=%0t)", nm, fld, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk(e.nm, "hit0",  {1'b0, hit0},  {1'b0, e.h0});
        chk(e.nm, "dout0", dout0,         e.d0);
        chk(e.nm, "hit1",  {1'b0, hit1},  {1'b0, e.h1});
        chk(e.nm, "dout1", dout1,         e.d1);
        chk(e.nm, "evict", {1'b0, evict}, {1'b0, e.ev});
      end
    end
  end

  // Without forwarding, the given values (the committed-state view) stand.
  // With forwarding, a live write to the same address is reported instead.
  task automatic port_exp(input logic rst_i, input logic we_i, input logic [29:0] wa_i,
                          input logic [1:0] din_i, input logic [29:0] ra_i,
                          input logic h_i, input logic [1:0] d_i,
                          output logic h_o, output logic [1:0] d_o);
    h_o = h_i;
    d_o = d_i;
`ifdef BP_CACHE_BYPASS_EN
    if (we_i && !rst_i && ra_i == wa_i) begin
      h_o = 1'b1;
      d_o = din_i;
    end
`endif
  endtask

  task automatic step(input string nm, input logic rst_i, input logic we_i,
                      input logic [29:0] wa_i, input logic [1:0] din_i,
                      input logic [29:0] ra0_i, input logic [29:0] ra1_i,
                      input logic h0, input logic [1:0] d0,
                      input logic h1, input logic [1:0] d1, input logic ev);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_i; we = we_i; wa = wa_i; din = din_i; ra0 = ra0_i; ra1 = ra1_i;
    e.cyc = cyc;
    e.nm  = nm;
    port_exp(rst_i, we_i, wa_i, din_i, ra0_i, h0, d0, e.h0, e.d0);
    port_exp(rst_i, we_i, wa_i, din_i, ra1_i, h1, d1, e.h1, e.d1);
    e.ev  = ev;
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wa = '0; din = '0; ra0 = '0; ra1 = '0;
    //     name           rst we  wa  din    ra0 ra1  h0 d0     h1 d1     ev
    step("rst_drop_wr",    1, 1,  A, 2'b11,  A,  A,   0, 2'b00, 0, 2'b00, 0);
    step("post_rst_miss",  0, 0,  Z, 2'b00,  A,  A,   0, 2'b00, 0, 2'b00, 0);
    step("wr_A",           0, 1,  A, 2'b01,  Z,  Z,   0, 2'b00, 0, 2'b00, 0);
    step("rd_A_both",      0, 0,  Z, 2'b00,  A,  A,   1, 2'b01, 1, 2'b01, 0);
    step("wr_B_rdw",       0, 1,  B, 2'b10,  A,  B,   1, 2'b01, 0, 2'b00, 0);
    step("rd_A_B",         0, 0,  Z, 2'b00,  A,  B,   1, 2'b01, 1, 2'b10, 0);
    step("wr_C_evict",     0, 1,  C, 2'b11,  A,  B,   1, 2'b01, 1, 2'b10, 1);
    step("rd_A_gone",      0, 0,  Z, 2'b00,  A,  C,   0, 2'b00, 1, 2'b11, 0);
    step("wr_D_evict",     0, 1,  D, 2'b01,  B,  C,   1, 2'b10, 1, 2'b11, 1);
    step("rd_C_D",         0, 0,  Z, 2'b00,  C,  D,   1, 2'b11, 1, 2'b01, 0);
    step("rd_B_A_gone",    0, 0,  Z, 2'b00,  B,  A,   0, 2'b00, 0, 2'b00, 0);
    step("wr_hit_D",       0, 1,  D, 2'b11,  C,  B,   1, 2'b11, 0, 2'b00, 0);
    step("rd_D_upd",       0, 0,  Z, 2'b00,  D,  C,   1, 2'b11, 1, 2'b11, 0);
    step("wr_E_evict_w0",  0, 1,  E, 2'b10,  D,  C,   1, 2'b11, 1, 2'b11, 1);
    step("rd_C_gone_E",    0, 0,  Z, 2'b00,  C,  E,   0, 2'b00, 1, 2'b10, 0);
    step("rd_D_E",         0, 0,  Z, 2'b00,  D,  E,   1, 2'b11, 1, 2'b10, 0);
    step("rst_mid",        1, 1,  F, 2'b01,  D,  E,   0, 2'b00, 0, 2'b00, 0);
    step("rd_D_F_miss",    0, 0,  Z, 2'b00,  D,  F,   0, 2'b00, 0, 2'b00, 0);
    step("rd_E_C_miss",    0, 0,  Z, 2'b00,  E,  C,   0, 2'b00, 0, 2'b00, 0);
    step("refill_A",       0, 1,  A, 2'b01,  B,  D,   0, 2'b00, 0, 2'b00, 0);
    step("refill_B",       0, 1,  B, 2'b10,  A,  C,   1, 2'b01, 0, 2'b00, 0);
    step("refill_C_ev",    0, 1,  C, 2'b11,  A,  B,   1, 2'b01, 1, 2'b10, 1);
    step("ptr_was_rst",    0, 0,  Z, 2'b00,  A,  B,   0, 2'b00, 1, 2'b10, 0);
    step("same_cyc_X",     0, 1,  X, 2'b10,  X,  A,   0, 2'b00, 0, 2'b00, 0);
    step("rd_X_next",      0, 0,  Z, 2'b00,  X,  C,   1, 2'b10, 1, 2'b11, 0);
    @(posedge clk);
    #1;
    we = 1'b0;
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
